// File: rtl/led_drive.sv
// ============================================================================
// Module   : led_drive
// Brief    : Single-pin LED driver with steady, PWM-dimmed, blink and flash modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_drive #(
    parameter int PWM_BITS   = 8,
    parameter int PRESC_DIV  = 50000,
    parameter int PRESC_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [7:0]          period,
    output logic                led,
    output logic                busy,
    output logic                tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_FLASH = 2'b11
    } mode_e;

    localparam logic [PRESC_BITS-1:0] C_PRESC_LAST = PRESC_BITS'(PRESC_DIV - 1);

    mode_e                 mode_q;
    logic [PWM_BITS-1:0]   duty_q;
    logic [7:0]            period_q;
    logic [PRESC_BITS-1:0] presc_q;
    logic [PWM_BITS-1:0]   pwm_cnt_q;
    logic [7:0]            tcnt_q;
    logic                  phase_q;
    logic                  led_q;
    logic                  busy_q;
    logic                  tick_q;

    logic                  presc_wrap;
    logic                  pwm_on;
    logic                  tcnt_last;
    logic                  led_d;

    // The timebase event is taken on the edge where the prescaler wraps; the
    // tick output is the registered image of that same event.
    assign presc_wrap = (presc_q == C_PRESC_LAST);
    assign pwm_on     = (&duty_q) | (pwm_cnt_q < duty_q);
    assign tcnt_last  = (tcnt_q == (period_q - 8'd1));

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_ON:    led_d = pwm_on;
            MODE_BLINK: led_d = phase_q & pwm_on;
            MODE_FLASH: led_d = busy_q & pwm_on;
            default:    led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_OFF;
            duty_q    <= '0;
            period_q  <= 8'd1;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            tcnt_q    <= '0;
            phase_q   <= 1'b1;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            led_q     <= led_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            tick_q    <= presc_wrap & ~wr;
            if (wr) begin
                // A write restarts the timebase and suppresses any coincident event.
                mode_q   <= mode_e'(mode);
                duty_q   <= duty;
                period_q <= (period == 8'd0) ? 8'd1 : period;
                presc_q  <= '0;
                tcnt_q   <= '0;
                phase_q  <= 1'b1;
                busy_q   <= (mode == MODE_FLASH);
            end else begin
                presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
                if (presc_wrap) begin
                    case (mode_q)
                        MODE_BLINK: begin
                            if (tcnt_last) begin
                                tcnt_q  <= '0;
                                phase_q <= ~phase_q;
                            end else begin
                                tcnt_q  <= tcnt_q + 8'd1;
                            end
                        end
                        MODE_FLASH: begin
                            if (tcnt_last) begin
                                tcnt_q <= '0;
                                busy_q <= 1'b0;
                                mode_q <= MODE_OFF;
                            end else begin
                                tcnt_q <= tcnt_q + 8'd1;
                            end
                        end
                        default: tcnt_q <= '0;
                    endcase
                end
            end
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_led_drive.sv
// ============================================================================
// Module   : tb_led_drive
// Brief    : Self-checking bench for led_drive against a time-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_drive;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       wr;
    logic [1:0] mode;
    logic [7:0] duty;
    logic [7:0] period;
    logic       led;
    logic       busy;
    logic       tick;

    int checks;
    int errors;

    // Reference model: configuration plus edges elapsed since the last restart.
    int m_mode;
    int m_duty;
    int m_per;
    int m_k;
    int m_p;
    bit exp_led;
    bit exp_busy;
    bit exp_tick;

    led_drive #(
        .PWM_BITS  (8),
        .PRESC_DIV (DIV),
        .PRESC_BITS(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .mode  (mode),
        .duty  (duty),
        .period(period),
        .led   (led),
        .busy  (busy),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_led();
        bit pwm;
        pwm = (m_duty == 255) || (m_p < m_duty);
        case (m_mode)
            1:       return pwm;
            2:       return ((((m_k / DIV) / m_per) % 2) == 0) && pwm;
            3:       return (m_k < DIV * m_per) && pwm;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input bit w, input logic [1:0] m, input logic [7:0] d, input logic [7:0] per);
        wr = w; mode = m; duty = d; period = per;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_duty = 0; m_per = 1; m_k = 0; m_p = 0;
            exp_led = 1'b0; exp_busy = 1'b0; exp_tick = 1'b0;
        end else begin
            exp_led = model_led();
            if (w) begin
                m_mode = int'(m); m_duty = int'(d);
                m_per  = (per == 8'd0) ? 1 : int'(per);
                m_k    = 0;
            end else begin
                m_k++;
            end
            m_p      = (m_p + 1) % 256;
            exp_busy = (m_mode == 3) && (m_k < DIV * m_per);
            exp_tick = (m_k > 0) && ((m_k % DIV) == 0);
        end
        #1;
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b11, 8'hFF, 8'h05);
            checks++;
            if ({led, busy, tick} !== 3'b000) begin
                errors++;
                $display("FAIL reset_outputs: led/busy/tick=%b%b%b expected 000", led, busy, tick);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            checks++;
            if (tick !== ((i % DIV) == 0) || tick !== exp_tick) begin
                errors++;
                $display("FAIL tick_period: cycle %0d tick=%b expected %b", i, tick, (i % DIV) == 0);
            end
        end
    endtask

    task automatic test_on();
        int highs;
        logic [7:0] duties [3] = '{8'h40, 8'hFF, 8'h00};
        int         want   [3] = '{64, 256, 0};
        for (int t = 0; t < 3; t++) begin
            step(1'b1, 2'b01, duties[t], 8'h01);
            highs = 0;
            for (int i = 0; i < 256; i++) begin
                idle(1);
                highs += int'(led);
                checks++;
                if (led !== exp_led) begin
                    errors++;
                    $display("FAIL on_model: duty=%h cycle %0d led=%b expected %b", duties[t], i, led, exp_led);
                end
            end
            checks++;
            if (highs != want[t]) begin
                errors++;
                $display("FAIL on_duty_count: duty=%h high cycles=%0d expected %0d", duties[t], highs, want[t]);
            end
        end
    endtask

    task automatic test_blink(input logic [7:0] per, input int half);
        step(1'b1, 2'b10, 8'hFF, per);
        for (int k = 1; k <= 4 * half; k++) begin
            idle(1);
            checks++;
            if (led !== (((k - 1) / half) % 2 == 0) || led !== exp_led) begin
                errors++;
                $display("FAIL blink_p%0d: cycle %0d led=%b expected %b", per, k, led, ((k - 1) / half) % 2 == 0);
            end
        end
    endtask

    task automatic test_flash();
        step(1'b1, 2'b11, 8'hFF, 8'h05);
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) idle(1);
            checks++;
            if (busy !== (k < 20) || (k > 0 && led !== (k <= 20))) begin
                errors++;
                $display("FAIL flash_len: cycle %0d busy=%b led=%b expected %b %b", k, busy, led, k < 20, k <= 20);
            end
        end
        step(1'b1, 2'b11, 8'hFF, 8'h05);
        idle(9);
        step(1'b1, 2'b11, 8'hFF, 8'h05);
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) idle(1);
            checks++;
            if (busy !== (k < 20) || led !== (k <= 20) || led !== exp_led) begin
                errors++;
                $display("FAIL flash_rearm: cycle %0d busy=%b led=%b expected %b %b", k, busy, led, k < 20, k <= 20);
            end
        end
    endtask

    task automatic test_wr_on_tick();
        step(1'b1, 2'b10, 8'hFF, 8'h01);
        idle(3);
        step(1'b1, 2'b10, 8'hFF, 8'h01);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL wr_on_tick: tick=%b expected 0", tick);
        end
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            checks++;
            if (tick !== ((k % DIV) == 0) || led !== (((k - 1) / DIV) % 2 == 0)) begin
                errors++;
                $display("FAIL wr_tick_restart: cycle %0d tick=%b led=%b expected %b %b",
                         k, tick, led, (k % DIV) == 0, ((k - 1) / DIV) % 2 == 0);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            step(($urandom % 24) == 0, 2'($urandom), d, 8'($urandom_range(0, 6)));
            checks++;
            if (led !== exp_led || busy !== exp_busy || tick !== exp_tick) begin
                errors++;
                $display("FAIL random_model: step %0d led/busy/tick=%b%b%b expected %b%b%b",
                         i, led, busy, tick, exp_led, exp_busy, exp_tick);
            end
        end
    endtask

    task automatic test_reset_mid_flash();
        step(1'b1, 2'b11, 8'hFF, 8'h0A);
        idle(7);
        rst = 1'b1;
        step(1'b0, 2'b00, 8'h00, 8'h00);
        rst = 1'b0;
        checks++;
        if (led !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flash: led=%b busy=%b expected 0 0", led, busy);
        end
        for (int k = 1; k <= 40; k++) begin
            idle(1);
            checks++;
            if (led !== 1'b0 || busy !== 1'b0 || tick !== exp_tick) begin
                errors++;
                $display("FAIL post_reset_quiet: cycle %0d led=%b busy=%b tick=%b expected 0 0 %b",
                         k, led, busy, tick, exp_tick);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; wr = 1'b0; mode = 2'b00; duty = 8'h00; period = 8'h00;
        m_mode = 0; m_duty = 0; m_per = 1; m_k = 0; m_p = 0;
        exp_led = 1'b0; exp_busy = 1'b0; exp_tick = 1'b0;
        @(negedge clk);
        test_reset();
        test_on();
        test_blink(8'd3, 3 * DIV);
        test_blink(8'd0, DIV);
        test_flash();
        test_wr_on_tick();
        test_random();
        test_reset_mid_flash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
